// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR round-robin arbiter.
// Holds the FSM state encoding, the LFSR core defaults and the data width
// default used by the arbiter top and its testbench.
package lfsr_pkg;

    // FSM state encoding of the arbiter sequencer.
    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'b00;
    localparam state_t GRANT  = 2'b01;
    localparam state_t STREAM = 2'b10;

    // Default width of the LFSR core output and of the streamed data.
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Reset-time seed and feedback taps of the shared LFSR core.
    // The arbiter never loads the core; these describe its power-on setup.
    localparam logic [7:0] LFSR_SEED = 8'h19;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Upper bound of the optional saturating statistics counters.
    localparam logic [15:0] STATS_MAX = 16'hFFFF;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// Returns the first set request bit at or above ptr, wrapping to bit 0,
// together with a flag telling whether any request is present.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any_req
);

    // Two ordered passes: bits from ptr upward first, then the wrapped bits below ptr.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_req && req[i] && (i >= int'(ptr))) begin
                winner  = ID_W'(i);
                any_req = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_req && req[i] && (i < int'(ptr))) begin
                winner  = ID_W'(i);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lfsr_rr_arbiter.sv
// Round-robin arbiter and sequencer sharing one LFSR core between requesters.
// A granted requester receives a burst of req_len LFSR values over a
// valid/ready stream tagged with its id; the core is advanced exactly once
// per delivered byte.
//
// Handshake: a beat transfers on a cycle where out_valid && out_ready are
// both high; out_valid, once raised, holds with stable data/id/last until the
// beat transfers. req_ready is a one-cycle accept pulse; requesters keep
// req_valid/req_len stable until they see it.
//
// Optional statistics: define LFSR_ARB_STATS_EN to add the beat_total and
// grant_total saturating counters and their output ports.
module lfsr_rr_arbiter
    import lfsr_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LEN_W      = 4,
    parameter int ID_W       = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [ID_W-1:0]          out_id,
    output logic                     out_last,
    output logic                     busy,
    output logic                     lfsr_enable,
    input  logic [DATA_WIDTH-1:0]    lfsr_data,
    output logic [1:0]               state_dbg
`ifdef LFSR_ARB_STATS_EN
    ,
    output logic [15:0]              beat_total,
    output logic [15:0]              grant_total
`endif
);

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_id;
    logic [LEN_W-1:0]  beat_cnt;

    logic [ID_W-1:0]   pick_winner;
    logic              pick_any;
    logic              fire;
    logic              grant_entry;
    logic [ID_W-1:0]   ptr_after_grant;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .winner  (pick_winner),
        .any_req (pick_any)
    );

    // Stream outputs are decoded straight from the registered state, so they
    // stay frozen while the consumer stalls.
    assign out_valid   = (state == STREAM);
    assign fire        = out_valid && out_ready;
    assign lfsr_enable = fire;
    assign out_last    = out_valid && (beat_cnt == LEN_W'(1));
    assign out_data    = lfsr_data;
    assign out_id      = grant_id;
    assign busy        = (state != IDLE);
    assign state_dbg   = state;

    // A grant is taken on the IDLE cycle that sees at least one request.
    assign grant_entry = (state == IDLE) && pick_any;

    // Next search start: one past the granted requester, wrapping at NUM_REQ.
    assign ptr_after_grant = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;

    // Sequencer FSM: pick a winner, pulse its accept, then stream its burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            beat_cnt  <= '0;
            req_ready <= '0;
        end else begin
            req_ready <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id  <= pick_winner;
                        beat_cnt  <= req_len[int'(pick_winner)*LEN_W +: LEN_W];
                        req_ready <= NUM_REQ'(1) << pick_winner;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    rr_ptr <= ptr_after_grant;
                    // Zero-length bursts are accepted but produce no beats.
                    if (beat_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (fire) begin
                        beat_cnt <= beat_cnt - 1'b1;
                        if (beat_cnt == LEN_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LFSR_ARB_STATS_EN
    // Saturating counts of delivered beats and of grants taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_total  <= '0;
            grant_total <= '0;
        end else begin
            if (fire && (beat_total != STATS_MAX)) begin
                beat_total <= beat_total + 16'd1;
            end
            if (grant_entry && (grant_total != STATS_MAX)) begin
                grant_total <= grant_total + 16'd1;
            end
        end
    end
`else
    // Without statistics the grant-entry decode has no consumer.
    logic unused_grant_entry;
    assign unused_grant_entry = grant_entry;
`endif

endmodule

// File: tb/tb_lfsr_rr_arbiter.sv
// Testbench for lfsr_rr_arbiter with a behavioural stand-in for the LFSR core.
// Per-cycle vector table for single burst, backpressure and zero-length
// bursts, then hand-written sequences for mid-burst reset, round-robin order,
// pointer wrap, re-request fairness and (with LFSR_ARB_STATS_EN) counters.
module tb_lfsr_rr_arbiter;
    import lfsr_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_len;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        out_last;
    logic        busy;
    logic        lfsr_enable;
    logic [7:0]  lfsr_data;
    logic [1:0]  state_dbg;
`ifdef LFSR_ARB_STATS_EN
    logic [15:0] beat_total;
    logic [15:0] grant_total;
`endif

    logic [7:0]  lfsr_q;
    logic        core_load;

    int n_chk;
    int n_err;

    logic [1:0] exp_q[$];

    lfsr_rr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .LEN_W      (4),
        .ID_W       (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_len     (req_len),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_id      (out_id),
        .out_last    (out_last),
        .busy        (busy),
        .lfsr_enable (lfsr_enable),
        .lfsr_data   (lfsr_data),
        .state_dbg   (state_dbg)
`ifdef LFSR_ARB_STATS_EN
        ,
        .beat_total  (beat_total),
        .grant_total (grant_total)
`endif
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // LFSR core stand-in: shift left, feedback bit is the parity of state & taps.
    always @(posedge clk) begin
        if (core_load) begin
            lfsr_q <= LFSR_SEED;
        end else if (lfsr_enable) begin
            lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end
    assign lfsr_data = lfsr_q;

    typedef struct {
        string      tag;
        logic [3:0] v;
        logic [15:0] len;
        logic       rdy;
        logic       load;
        logic [3:0] e_rr;
        logic [1:0] e_st;
        logic       e_ov;
        logic [7:0] e_d;
        logic [1:0] e_id;
        logic       e_last;
        logic       e_en;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input string tag, input logic [3:0] v, input logic [15:0] len,
                                input logic rdy, input logic load, input logic [3:0] e_rr,
                                input logic [1:0] e_st, input logic e_ov, input logic [7:0] e_d,
                                input logic [1:0] e_id, input logic e_last, input logic e_en);
        vec_t r;
        r.tag = tag; r.v = v; r.len = len; r.rdy = rdy; r.load = load; r.e_rr = e_rr;
        r.e_st = e_st; r.e_ov = e_ov; r.e_d = e_d; r.e_id = e_id; r.e_last = e_last; r.e_en = e_en;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives the queued grant order; hold=1 keeps requests asserted (immediate re-request).
    task automatic run_grants(input logic hold, input string tag);
        int         cyc;
        int         first;
        logic [1:0] cur;
        logic [1:0] want;
        cyc   = 0;
        first = -1;
        cur   = 2'd0;
        while ((exp_q.size() != 0 || state_dbg != IDLE) && cyc < 100) begin
            @(negedge clk); #1;
            cyc++;
            if (req_ready != 4'b0000) begin
                if (first < 0) begin
                    first = cyc;
                    chk({tag, " first_latency"}, 32'(first), 32'd1);
                end
                if (exp_q.size() == 0) begin
                    chk({tag, " extra_grant"}, 32'(req_ready), 32'd0);
                end else begin
                    want = exp_q.pop_front();
                    chk({tag, " grant"}, 32'(req_ready), 32'(4'b0001 << want));
                    cur = want;
                    if (!hold) req_valid[want] = 1'b0;
                    if (exp_q.size() == 0) req_valid = 4'b0000;
                end
            end
            if (out_valid) begin
                chk({tag, " out_id"}, 32'(out_id), 32'(cur));
                chk({tag, " out_last"}, 32'(out_last), 32'd1);
            end
        end
        chk({tag, " done"}, 32'(exp_q.size() == 0 && state_dbg == IDLE), 32'd1);
        exp_q.delete();
        req_valid = 4'b0000;
        repeat (2) begin
            @(negedge clk); #1;
            chk({tag, " quiet"}, 32'(req_ready), 32'd0);
        end
    endtask

    initial begin
        int         beats;
        logic [7:0] exp_d[2];
        vec_t       v;
        n_chk = 0;
        n_err = 0;
        exp_d[0] = 8'h19;
        exp_d[1] = 8'h32;

        // Reset
        rst = 1'b1; core_load = 1'b1;
        req_valid = 4'b0000; req_len = 16'h0000; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0; core_load = 1'b0;
        chk("reset state", 32'(state_dbg), 32'(IDLE));
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_last", 32'(out_last), 32'd0);
        chk("reset lfsr_enable", 32'(lfsr_enable), 32'd0);
`ifdef LFSR_ARB_STATS_EN
        chk("reset beat_total", 32'(beat_total), 32'd0);
        chk("reset grant_total", 32'(grant_total), 32'd0);
`endif

        // Single burst of 4 from requester 0.
        vt.push_back(mk("single", 4'b0001, 16'h0004, 1'b1, 1'b0, 4'b0000, IDLE,   1'b0, 8'h00, 2'd0, 1'b0, 1'b0));
        vt.push_back(mk("single", 4'b0001, 16'h0004, 1'b1, 1'b0, 4'b0001, GRANT,  1'b0, 8'h00, 2'd0, 1'b0, 1'b0));
        vt.push_back(mk("single", 4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, STREAM, 1'b1, 8'h19, 2'd0, 1'b0, 1'b1));
        vt.push_back(mk("single", 4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, STREAM, 1'b1, 8'h32, 2'd0, 1'b0, 1'b1));
        vt.push_back(mk("single", 4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, STREAM, 1'b1, 8'h64, 2'd0, 1'b0, 1'b1));
        vt.push_back(mk("single", 4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, STREAM, 1'b1, 8'hC9, 2'd0, 1'b1, 1'b1));
        vt.push_back(mk("single", 4'b0000, 16'h0000, 1'b1, 1'b1, 4'b0000, IDLE,   1'b0, 8'h00, 2'd0, 1'b0, 1'b0));
        // Backpressure: requester 1, len 3, out_ready 1,0,0,1,1.
        vt.push_back(mk("bp", 4'b0010, 16'h0030, 1'b1, 1'b0, 4'b0000, IDLE,   1'b0, 8'h00, 2'd1, 1'b0, 1'b0));
        vt.push_back(mk("bp", 4'b0010, 16'h0030, 1'b1, 1'b0, 4'b0010, GRANT,  1'b0, 8'h00, 2'd1, 1'b0, 1'b0));
        vt.push_back(mk("bp", 4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, STREAM, 1'b1, 8'h19, 2'd1, 1'b0, 1'b1));
        vt.push_back(mk("bp", 4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0000, STREAM, 1'b1, 8'h32, 2'd1, 1'b0, 1'b0));
        vt.push_back(mk("bp", 4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0000, STREAM, 1'b1, 8'h32, 2'd1, 1'b0, 1'b0));
        vt.push_back(mk("bp", 4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, STREAM, 1'b1, 8'h32, 2'd1, 1'b0, 1'b1));
        vt.push_back(mk("bp", 4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, STREAM, 1'b1, 8'h64, 2'd1, 1'b1, 1'b1));
        vt.push_back(mk("bp", 4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, IDLE,   1'b0, 8'h00, 2'd1, 1'b0, 1'b0));
        // Zero-length burst from requester 2.
        vt.push_back(mk("zero", 4'b0100, 16'h0000, 1'b1, 1'b0, 4'b0000, IDLE,  1'b0, 8'h00, 2'd2, 1'b0, 1'b0));
        vt.push_back(mk("zero", 4'b0100, 16'h0000, 1'b1, 1'b0, 4'b0100, GRANT, 1'b0, 8'h00, 2'd2, 1'b0, 1'b0));
        vt.push_back(mk("zero", 4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, IDLE,  1'b0, 8'h00, 2'd2, 1'b0, 1'b0));
        vt.push_back(mk("zero", 4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, IDLE,  1'b0, 8'h00, 2'd2, 1'b0, 1'b0));

        for (int k = 0; k < vt.size(); k++) begin
            v = vt[k];
            @(negedge clk);
            req_valid = v.v; req_len = v.len; out_ready = v.rdy; core_load = v.load;
            #1;
            chk($sformatf("%s[%0d] req_ready", v.tag, k), 32'(req_ready), 32'(v.e_rr));
            chk($sformatf("%s[%0d] state", v.tag, k), 32'(state_dbg), 32'(v.e_st));
            chk($sformatf("%s[%0d] busy", v.tag, k), 32'(busy), 32'(v.e_st != IDLE));
            chk($sformatf("%s[%0d] out_valid", v.tag, k), 32'(out_valid), 32'(v.e_ov));
            chk($sformatf("%s[%0d] out_last", v.tag, k), 32'(out_last), 32'(v.e_last));
            chk($sformatf("%s[%0d] lfsr_enable", v.tag, k), 32'(lfsr_enable), 32'(v.e_en));
            if (v.e_ov) begin
                chk($sformatf("%s[%0d] out_data", v.tag, k), 32'(out_data), 32'(v.e_d));
                chk($sformatf("%s[%0d] out_id", v.tag, k), 32'(out_id), 32'(v.e_id));
            end
        end
        core_load = 1'b0;
`ifdef LFSR_ARB_STATS_EN
        chk("stats table beat_total", 32'(beat_total), 32'd7);
        chk("stats table grant_total", 32'(grant_total), 32'd3);
`endif

        // Mid-burst reset: len 5 from requester 0, reset after 2 beats.
        @(negedge clk); #1;
        core_load = 1'b1; req_valid = 4'b0001; req_len = 16'h0005; out_ready = 1'b1;
        @(negedge clk); #1;
        core_load = 1'b0;
        chk("rstmid grant", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        beats = 0;
        for (int c = 0; c < 10 && beats < 2; c++) begin
            @(negedge clk); #1;
            if (out_valid && out_ready) begin
                chk($sformatf("rstmid beat%0d data", beats), 32'(out_data), 32'(exp_d[beats]));
                beats++;
            end
        end
        chk("rstmid beats", 32'(beats), 32'd2);
        @(posedge clk); #1;
        rst = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        chk("rstmid out_valid", 32'(out_valid), 32'd0);
        chk("rstmid busy", 32'(busy), 32'd0);
        chk("rstmid state", 32'(state_dbg), 32'(IDLE));
        chk("rstmid lfsr_enable", 32'(lfsr_enable), 32'd0);
        chk("rstmid req_ready", 32'(req_ready), 32'd0);
`ifdef LFSR_ARB_STATS_EN
        chk("rstmid beat_total", 32'(beat_total), 32'd0);
        chk("rstmid grant_total", 32'(grant_total), 32'd0);
`endif

        // All four requesters, len 1 each: order 0,1,2,3 proves rr_ptr restarted at 0.
        req_valid = 4'b1111; req_len = 16'h1111;
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
        run_grants(1'b0, "rr4");

        // Pointer wrapped to 0: requesters 3 and 0 compete, 0 wins.
        req_valid = 4'b1001; req_len = 16'h1001;
        exp_q.push_back(2'd0);
        run_grants(1'b0, "wrap");

        // Requester 0 re-requests immediately; requester 1 must be served first.
        req_valid = 4'b0011; req_len = 16'h0011;
        exp_q.push_back(2'd1); exp_q.push_back(2'd0);
        run_grants(1'b1, "fair");

`ifdef LFSR_ARB_STATS_EN
        chk("stats rr beat_total", 32'(beat_total), 32'd7);
        chk("stats rr grant_total", 32'(grant_total), 32'd7);

        // Back-to-back 15-beat bursts: 4400 x 15 = 66000 beats saturates beat_total.
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0; req_valid = 4'b0001; req_len = 16'h000F; out_ready = 1'b1;
        repeat (17 * 4400) @(posedge clk);
        @(negedge clk); #1;
        chk("sat beat_total", 32'(beat_total), 32'hFFFF);
        chk("sat grant_total", 32'(grant_total), 32'd4400);
        req_valid = 4'b0000;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lfsr_rr_arbiter.md
Name: lfsr_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 8-bit LFSR core between NUM_REQ requesters.
- Each requester asks for a burst of random bytes.
- The arbiter grants one requester at a time and streams that many LFSR values to it over a valid/ready output tagged with the requester id.
- It drives the core's enable so the LFSR advances exactly once per delivered byte.
- Sits between the LFSR core (enable/data) and consumer blocks; seed/taps/load stay with the register slave.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, width of LFSR data and out_data
- LEN_W, 4, width of each burst-length field (max burst 2^LEN_W-1)
- ID_W, 2, width of out_id; must satisfy 2^ID_W >= NUM_REQ

Ports:
- clk, input, 1, system clock
- rst, input, 1, synchronous active-high reset
- req_valid, input, NUM_REQ, per-requester burst request
- req_len, input, NUM_REQ*LEN_W, packed burst lengths; requester i uses bits [i*LEN_W +: LEN_W]
- req_ready, output, NUM_REQ, one-cycle accept pulse to the granted requester
- out_valid, output, 1, out_data valid
- out_ready, input, 1, consumer accepts beat
- out_data, output, DATA_WIDTH, current LFSR value (passthrough of lfsr_data)
- out_id, output, ID_W, index of the granted requester
- out_last, output, 1, final beat of burst
- busy, output, 1, state != IDLE
- lfsr_enable, output, 1, advance LFSR core one step
- lfsr_data, input, DATA_WIDTH, LFSR core output register

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0.
  - req_ready=0, out_valid=0, out_last=0, busy=0, lfsr_enable=0.
  - Reset mid-burst abandons the burst; no further beats; out_valid low from the next cycle.
- FSM states:
  - IDLE:
    - If any req_valid, pick the first set bit searching from rr_ptr upward with wrap.
    - Latch grant_id=winner and beat_cnt=req_len[winner]; go to GRANT.
  - GRANT:
    - req_ready[grant_id]=1 for exactly this cycle (registered decode); all other bits 0.
    - rr_ptr <= grant_id+1, wrapping at NUM_REQ.
    - If beat_cnt==0: zero-length burst accepted; go to IDLE with no beats.
    - Otherwise go to STREAM.
  - STREAM:
    - out_valid=1, out_id=grant_id, out_data=lfsr_data, out_last=(beat_cnt==1).
    - On out_valid&&out_ready: lfsr_enable=1 (combinational, that cycle only) and beat_cnt decrements.
    - If that beat had out_last=1, go to IDLE.
    - With out_ready low: hold all outputs, lfsr_enable=0, no data change.
- Requester rules:
  - Hold req_valid and req_len stable until its req_ready pulse.
  - req_valid changes after grant are ignored for the active burst.
  - A requester may re-request immediately; round-robin guarantees the others get a turn first.
- Latency:
  - req_valid seen in IDLE at cycle 0 → req_ready at cycle 1 → first out_valid at cycle 2.
  - After the last beat, IDLE at the next cycle.
  - Minimum inter-burst gap: 2 cycles (IDLE, GRANT).
- lfsr_enable is never asserted outside STREAM. The arbiter never drives load, so core stuck-zero recovery and seeding remain the core's concern.
- Simultaneous requests: strict round-robin from rr_ptr; no starvation.

Optional Feature:
- Macro: LFSR_ARB_STATS_EN.
- Defined:
  - Adds output beat_total [15:0], a saturating count of all delivered beats (increments on out_valid&&out_ready, sticks at 0xFFFF).
  - Adds output grant_total [15:0], a saturating count of GRANT entries.
  - Both clear on rst.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

Decomposition:
- Shared package lfsr_pkg:
  - FSM state encoding (IDLE=2'b00, GRANT=2'b01, STREAM=2'b10).
  - LFSR default seed 8'h19 and default taps constant 8'hB8.
  - DATA_WIDTH default.
- Sub-module rr_pick: combinational round-robin priority picker; inputs req vector and rr_ptr; outputs winner index and any_req.

Test Plan:
- Single request, core reset to seed 0x19, taps 0xB8, req_len[0]=4, out_ready=1:
  - req_ready[0] pulses at cycle 1.
  - Beats 0x19, 0x32, 0x64, 0xC9 with out_id=0; out_last only on 0xC9; lfsr_enable high 4 cycles.
- All four req_valid high with len=1 each: grants in order 0,1,2,3; rr_ptr wraps to 0; each req_ready pulses once.
- Backpressure, len=3, out_ready toggled 1,0,0,1,1:
  - out_data frozen during the stall cycles, lfsr_enable low during the stall.
  - Exactly 3 beats: 0x19, 0x32, 0x64.
- req_len=0 from requester 2: req_ready[2] pulses, no out_valid, back to IDLE 2 cycles after request.
- rst asserted mid-burst (after 2 of 5 beats):
  - Next cycle out_valid=0, busy=0, rr_ptr=0.
  - A new request restarts from IDLE.
- With LFSR_ARB_STATS_EN: after the bursts above, beat_total and grant_total match the expected counts. Force 70000 beats: beat_total saturates at 0xFFFF.
